// File: rtl/fft_uart_pkg.sv
// ---------------------------------------------------------------------------
// fft_uart_pkg
// Shared definitions for the UART <-> FFT framing blocks.
//   - state_t      : framer FSM encoding (ST_IDLE / ST_COLLECT / ST_FULL)
//   - DEF_*        : default geometry used as module parameter defaults
//   - FRAME_BYTES  : bytes per frame for the default geometry (2 bytes/sample)
//   - clog2()      : counter width helper, never returns less than 1
// ---------------------------------------------------------------------------
package fft_uart_pkg;

  localparam int DEF_FFT_SIZE      = 32;
  localparam int DEF_WORD_SIZE     = 16;
  localparam int DEF_DATA_LENGTH   = 8;
  localparam int DEF_CLOCK_PER_BIT = 868;
  localparam int DEF_TIMEOUT_BITS  = 40;

  localparam int FRAME_BYTES = 2 * DEF_FFT_SIZE;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_FULL    = 2'd2
  } state_t;

  // Bits needed to hold values 0..value-1; a 1-bit minimum keeps
  // degenerate parameterisations from producing zero-width vectors.
  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/uart_idle_timer.sv
// ---------------------------------------------------------------------------
// uart_idle_timer
// Counts idle clocks between received bytes and flags the clock on which the
// count reaches LIMIT.
// Ports:
//   i_clk      system clock (rising edge)
//   i_rst      synchronous, active-low reset
//   i_clear    restart the count from zero (has priority over i_tick)
//   i_tick     count this clock as idle
//   o_expired  high for the clock whose tick takes the count to LIMIT
// The count saturates at LIMIT rather than wrapping, so a caller that keeps
// ticking never sees a second expiry without an intervening clear.
// ---------------------------------------------------------------------------
module uart_idle_timer
  import fft_uart_pkg::*;
#(
  parameter int LIMIT = DEF_CLOCK_PER_BIT * DEF_TIMEOUT_BITS
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_expired
);

  localparam int CNT_W = clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST_IDLE = CNT_W'(LIMIT - 1);
  localparam logic [CNT_W-1:0] SAT_VALUE = CNT_W'(LIMIT);

  logic [CNT_W-1:0] idle_count;

  // Expiry is decoded combinationally so the framer can act on the very edge
  // the limit is reached; a clear on that same clock suppresses it, which is
  // how a late byte wins over the timeout.
  assign o_expired = i_tick && !i_clear && (idle_count == LAST_IDLE);

  // Idle counter: clear first, then saturating increment.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      idle_count <= '0;
    end else if (i_clear) begin
      idle_count <= '0;
    end else if (i_tick && (idle_count != SAT_VALUE)) begin
      idle_count <= idle_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// uart_frame_assembler
// Input-side framer for the FFT datapath. Packs the UART byte stream (low
// byte first) into WORD_SIZE-bit samples, buffers FFT_SIZE samples and offers
// them as one frame with a valid/ack handshake. A partial frame is dropped
// after TIMEOUT_BITS bit times of silence so the host can always resync.
// Ports:
//   i_clk          system clock (rising edge)
//   i_rst          synchronous, active-low reset
//   i_byte         received byte, sampled when i_byte_valid=1
//   i_byte_valid   one-cycle strobe per received byte
//   i_frame_ack    consumer took the frame (only honoured while frame valid)
//   o_frame        packed frame, sample k at [k*WORD_SIZE +: WORD_SIZE]
//   o_frame_valid  frame complete and held stable
//   o_byte_count   bytes accepted into the current frame (0..2*FFT_SIZE)
//   o_overrun      one-cycle pulse: byte dropped while a frame is pending
//   o_timeout      one-cycle pulse: partial frame discarded
// ---------------------------------------------------------------------------
module uart_frame_assembler
  import fft_uart_pkg::*;
#(
  parameter int FFT_SIZE      = DEF_FFT_SIZE,
  parameter int WORD_SIZE     = DEF_WORD_SIZE,
  parameter int DATA_LENGTH   = DEF_DATA_LENGTH,
  parameter int CLOCK_PER_BIT = DEF_CLOCK_PER_BIT,
  parameter int TIMEOUT_BITS  = DEF_TIMEOUT_BITS
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_LENGTH-1:0]        i_byte,
  input  logic                          i_byte_valid,
  input  logic                          i_frame_ack,
  output logic [FFT_SIZE*WORD_SIZE-1:0] o_frame,
  output logic                          o_frame_valid,
  output logic [6:0]                    o_byte_count,
  output logic                          o_overrun,
  output logic                          o_timeout
);

  localparam int N_BYTES       = 2 * FFT_SIZE;
  localparam int FRAME_W       = FFT_SIZE * WORD_SIZE;
  localparam int TIMEOUT_LIMIT = CLOCK_PER_BIT * TIMEOUT_BITS;

  localparam logic [6:0] LAST_BYTE = 7'(N_BYTES - 1);

  state_t             state;
  logic [6:0]         byte_count;
  logic [FRAME_W-1:0] frame;
  logic               frame_valid;
  logic               overrun;
  logic               timeout;

  logic               wr_en;
  logic [6:0]         wr_idx;

  logic               idle_clear;
  logic               idle_tick;
  logic               idle_expired;

  // The timer only runs while a partial frame is open. Any other state, and
  // every accepted byte, restarts it so a new frame always gets the full
  // timeout window.
  assign idle_tick  = (state == ST_COLLECT) && !i_byte_valid;
  assign idle_clear = (state != ST_COLLECT) || i_byte_valid;

  uart_idle_timer #(
    .LIMIT(TIMEOUT_LIMIT)
  ) u_idle_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   (idle_clear),
    .i_tick    (idle_tick),
    .o_expired (idle_expired)
  );

  // Byte write decode. The byte index equals the running count, and because
  // a sample is exactly two bytes, byte n lands in sample n/2, low half for
  // even n. A byte arriving with the ack of a full frame restarts at index 0.
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = byte_count;
    case (state)
      ST_IDLE:    wr_en = i_byte_valid;
      ST_COLLECT: wr_en = i_byte_valid;
      ST_FULL: begin
        wr_en  = i_byte_valid && i_frame_ack;
        wr_idx = '0;
      end
      default: begin
        wr_en  = 1'b0;
        wr_idx = '0;
      end
    endcase
  end

  // Frame storage: flat register bank written one byte lane at a time.
  // Not cleared on timeout; stale lanes are simply overwritten by the next
  // frame before it can become valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      frame <= '0;
    end else if (wr_en) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (wr_idx == 7'(b)) begin
          frame[b*DATA_LENGTH +: DATA_LENGTH] <= i_byte;
        end
      end
    end
  end

  // Framer FSM with registered handshake and status pulses.
  // In COLLECT an arriving byte is tested before the timer expiry, so a byte
  // landing on the expiry clock is kept (the timer also suppresses expiry
  // when cleared, this ordering makes the intent explicit here too).
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state       <= ST_IDLE;
      byte_count  <= '0;
      frame_valid <= 1'b0;
      overrun     <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      overrun <= 1'b0;
      timeout <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_byte_valid) begin
            byte_count <= 7'd1;
            state      <= ST_COLLECT;
          end
        end

        ST_COLLECT: begin
          if (i_byte_valid) begin
            byte_count <= byte_count + 7'd1;
            if (byte_count == LAST_BYTE) begin
              state       <= ST_FULL;
              frame_valid <= 1'b1;
            end
          end else if (idle_expired) begin
            byte_count <= '0;
            state      <= ST_IDLE;
            timeout    <= 1'b1;
          end
        end

        ST_FULL: begin
          if (i_frame_ack) begin
            frame_valid <= 1'b0;
            if (i_byte_valid) begin
              byte_count <= 7'd1;
              state      <= ST_COLLECT;
            end else begin
              byte_count <= '0;
              state      <= ST_IDLE;
            end
          end else if (i_byte_valid) begin
            overrun <= 1'b1;
          end
        end

        default: begin
          state       <= ST_IDLE;
          byte_count  <= '0;
          frame_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_frame       = frame;
  assign o_frame_valid = frame_valid;
  assign o_byte_count  = byte_count;
  assign o_overrun     = overrun;
  assign o_timeout     = timeout;

endmodule

// File: tb/tb_uart_frame_assembler.sv
// ---------------------------------------------------------------------------
// tb_uart_frame_assembler
// Scoreboard bench: every complete frame the stimulus produces is pushed to
// exp_frames as it is driven and popped when the DUT raises o_frame_valid.
// A short timeout (CLOCK_PER_BIT=4, TIMEOUT_BITS=2 -> 8 idle clocks) keeps
// the timeout scenarios fast.
// ---------------------------------------------------------------------------
module tb_uart_frame_assembler;

  localparam int FFT_SIZE      = 32;
  localparam int WORD_SIZE     = 16;
  localparam int DATA_LENGTH   = 8;
  localparam int CLOCK_PER_BIT = 4;
  localparam int TIMEOUT_BITS  = 2;
  localparam int NB            = 2 * FFT_SIZE;
  localparam int FW            = FFT_SIZE * WORD_SIZE;
  localparam int TMO           = CLOCK_PER_BIT * TIMEOUT_BITS;

  logic                   i_clk        = 1'b0;
  logic                   i_rst        = 1'b0;
  logic [DATA_LENGTH-1:0] i_byte       = '0;
  logic                   i_byte_valid = 1'b0;
  logic                   i_frame_ack  = 1'b0;
  logic [FW-1:0]          o_frame;
  logic                   o_frame_valid;
  logic [6:0]             o_byte_count;
  logic                   o_overrun;
  logic                   o_timeout;

  uart_frame_assembler #(
    .FFT_SIZE      (FFT_SIZE),
    .WORD_SIZE     (WORD_SIZE),
    .DATA_LENGTH   (DATA_LENGTH),
    .CLOCK_PER_BIT (CLOCK_PER_BIT),
    .TIMEOUT_BITS  (TIMEOUT_BITS)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_byte        (i_byte),
    .i_byte_valid  (i_byte_valid),
    .i_frame_ack   (i_frame_ack),
    .o_frame       (o_frame),
    .o_frame_valid (o_frame_valid),
    .o_byte_count  (o_byte_count),
    .o_overrun     (o_overrun),
    .o_timeout     (o_timeout)
  );

  always #5 i_clk = ~i_clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model of the framer.
  logic [7:0]    model_bytes [NB];
  int            model_count = 0;
  bit            model_full  = 1'b0;
  logic [FW-1:0] exp_frames [$];

  // Pulse / edge monitor. Sampled on the rising edge, so it sees the values
  // held during the preceding cycle.
  int   overrun_seen = 0;
  int   timeout_seen = 0;
  int   valid_rises  = 0;
  logic prev_valid   = 1'b0;

  always @(posedge i_clk) begin
    if (o_overrun === 1'b1) overrun_seen++;
    if (o_timeout === 1'b1) timeout_seen++;
    if (o_frame_valid === 1'b1 && prev_valid !== 1'b1) valid_rises++;
    prev_valid <= o_frame_valid;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [FW-1:0] pack_model();
    logic [FW-1:0] f;
    f = '0;
    for (int i = 0; i < NB; i++) f[i*8 +: 8] = model_bytes[i];
    return f;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) model_bytes[i] = 8'h00;
    model_count = 0;
    model_full  = 1'b0;
    exp_frames.delete();
  endtask

  task automatic hard_reset();
    i_rst        = 1'b0;
    i_byte_valid = 1'b0;
    i_frame_ack  = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b1;
    model_clear();
  endtask

  // Drive one byte strobe (optionally with ack); strobe period is 'gap' clocks.
  task automatic send_byte(input logic [7:0] b, input bit ack, input int gap);
    i_byte       = b;
    i_byte_valid = 1'b1;
    i_frame_ack  = ack;
    @(negedge i_clk);
    i_byte_valid = 1'b0;
    i_frame_ack  = 1'b0;
    if (model_full) begin
      if (ack) begin
        model_full     = 1'b0;
        model_bytes[0] = b;
        model_count    = 1;
      end
    end else begin
      model_bytes[model_count] = b;
      model_count++;
      if (model_count == NB) begin
        model_full = 1'b1;
        exp_frames.push_back(pack_model());
      end
    end
    repeat (gap - 1) @(negedge i_clk);
  endtask

  task automatic send_ack();
    i_frame_ack = 1'b1;
    @(negedge i_clk);
    i_frame_ack = 1'b0;
    if (model_full) begin
      model_full  = 1'b0;
      model_count = 0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
    if (!model_full && model_count > 0 && n >= TMO) model_count = 0;
  endtask

  task automatic test_reset();
    @(negedge i_clk);
    repeat (3) @(negedge i_clk);
    n_vec++;
    if (o_frame !== '0) begin n_err++; $display("[TB] FAIL reset_frame: got %h required 0", o_frame); end
    n_vec++;
    if (o_frame_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid: got %b required 0", o_frame_valid); end
    n_vec++;
    if (o_byte_count !== 7'd0) begin n_err++; $display("[TB] FAIL reset_count: got %0d required 0", o_byte_count); end
    n_vec++;
    if ({o_overrun, o_timeout} !== 2'b00) begin n_err++; $display("[TB] FAIL reset_pulses: got %b required 00", {o_overrun, o_timeout}); end
    i_rst = 1'b1;
    model_clear();
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 * (i + 1)), 1'b0, 1);
    n_vec++;
    if (o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL pre_reset_count: got %0d required %0d", o_byte_count, model_count); end
    hard_reset();
    n_vec++;
    if ({o_frame_valid, o_byte_count, o_frame} !== '0) begin n_err++; $display("[TB] FAIL midcollect_reset: got valid=%b count=%0d frame=%h required all 0", o_frame_valid, o_byte_count, o_frame); end
    send_byte(8'h5A, 1'b0, 1);
    n_vec++;
    if (o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL post_reset_count: got %0d required %0d", o_byte_count, model_count); end
    n_vec++;
    if (o_frame[15:0] !== {model_bytes[1], model_bytes[0]}) begin n_err++; $display("[TB] FAIL post_reset_sample0: got %h required %h", o_frame[15:0], {model_bytes[1], model_bytes[0]}); end
  endtask

  task automatic test_full_frame();
    logic [FW-1:0] exp;
    hard_reset();
    for (int i = 0; i < NB - 1; i++) send_byte(8'(i), 1'b0, 5);
    n_vec++;
    if (o_frame_valid !== 1'b0 || o_byte_count !== 7'(NB - 1)) begin n_err++; $display("[TB] FAIL before_last_byte: got valid=%b count=%0d required 0/%0d", o_frame_valid, o_byte_count, NB - 1); end
    send_byte(8'(NB - 1), 1'b0, 1);
    n_vec++;
    if (o_frame_valid !== 1'b1) begin n_err++; $display("[TB] FAIL valid_latency: got %b required 1 one clock after last strobe", o_frame_valid); end
    n_vec++;
    if (o_byte_count !== 7'(NB)) begin n_err++; $display("[TB] FAIL full_count: got %0d required %0d", o_byte_count, NB); end
    n_vec++;
    if (exp_frames.size() == 0) begin n_err++; $display("[TB] FAIL sb_full_frame: got empty scoreboard required one frame"); end
    else begin
      exp = exp_frames.pop_front();
      if (o_frame !== exp) begin n_err++; $display("[TB] FAIL sb_full_frame: got %h required %h", o_frame, exp); end
    end
    n_vec++;
    if (o_frame[15:0] !== 16'h0100) begin n_err++; $display("[TB] FAIL sample0: got %h required 0100", o_frame[15:0]); end
    n_vec++;
    if (o_frame[31*16 +: 16] !== 16'h3F3E) begin n_err++; $display("[TB] FAIL sample31: got %h required 3f3e", o_frame[31*16 +: 16]); end
  endtask

  task automatic test_backpressure();
    logic [FW-1:0] saved;
    int base;
    saved = pack_model();
    base  = overrun_seen;
    for (int i = 0; i < 3; i++) send_byte(8'(8'hE0 + i), 1'b0, 2);
    @(negedge i_clk);
    n_vec++;
    if (overrun_seen - base !== 3) begin n_err++; $display("[TB] FAIL overrun_pulses: got %0d required 3", overrun_seen - base); end
    n_vec++;
    if (o_frame !== saved) begin n_err++; $display("[TB] FAIL frame_held: got %h required %h", o_frame, saved); end
    n_vec++;
    if (o_frame_valid !== 1'b1 || o_byte_count !== 7'(NB)) begin n_err++; $display("[TB] FAIL full_held: got valid=%b count=%0d required 1/%0d", o_frame_valid, o_byte_count, NB); end
    send_ack();
    n_vec++;
    if (o_frame_valid !== 1'b0 || o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL after_ack: got valid=%b count=%0d required 0/%0d", o_frame_valid, o_byte_count, model_count); end
  endtask

  task automatic test_ack_with_byte();
    logic [FW-1:0] exp;
    int base;
    int t;
    for (int i = 0; i < NB; i++) send_byte(8'($urandom), 1'b0, 1);
    t = 0;
    while (o_frame_valid !== 1'b1 && t < 4) begin @(negedge i_clk); t++; end
    n_vec++;
    if (o_frame_valid !== 1'b1 || exp_frames.size() == 0) begin n_err++; $display("[TB] FAIL sb_random_frame: got valid=%b queued=%0d required valid frame", o_frame_valid, exp_frames.size()); end
    else begin
      exp = exp_frames.pop_front();
      if (o_frame !== exp) begin n_err++; $display("[TB] FAIL sb_random_frame: got %h required %h", o_frame, exp); end
    end
    base = overrun_seen;
    send_byte(8'hA5, 1'b1, 1);
    n_vec++;
    if (o_frame_valid !== 1'b0 || o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL ack_byte_state: got valid=%b count=%0d required 0/%0d", o_frame_valid, o_byte_count, model_count); end
    n_vec++;
    if (o_frame[7:0] !== 8'hA5) begin n_err++; $display("[TB] FAIL ack_byte_sample0: got %h required a5", o_frame[7:0]); end
    @(negedge i_clk);
    n_vec++;
    if (overrun_seen !== base) begin n_err++; $display("[TB] FAIL ack_byte_overrun: got %0d pulses required 0", overrun_seen - base); end
    idle(TMO + 4);
  endtask

  task automatic test_timeout();
    int base;
    hard_reset();
    for (int i = 0; i < 10; i++) send_byte(8'(8'h20 + i), 1'b0, 1);
    repeat (TMO - 1) @(negedge i_clk);
    n_vec++;
    if (o_timeout !== 1'b0 || o_byte_count !== 7'd10) begin n_err++; $display("[TB] FAIL early_timeout: got timeout=%b count=%0d required 0/10", o_timeout, o_byte_count); end
    @(negedge i_clk);
    model_count = 0;
    n_vec++;
    if (o_timeout !== 1'b1 || o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL timeout_fire: got timeout=%b count=%0d required 1/0", o_timeout, o_byte_count); end
    @(negedge i_clk);
    n_vec++;
    if (o_timeout !== 1'b0) begin n_err++; $display("[TB] FAIL timeout_one_cycle: got %b required 0", o_timeout); end
    base = timeout_seen;
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i), 1'b0, 1);
    repeat (TMO - 1) @(negedge i_clk);
    send_byte(8'h77, 1'b0, 1);
    n_vec++;
    if (o_timeout !== 1'b0 || o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL byte_on_expiry: got timeout=%b count=%0d required 0/%0d", o_timeout, o_byte_count, model_count); end
    idle(TMO + 4);
    @(negedge i_clk);
    n_vec++;
    if (timeout_seen - base !== 1 || o_byte_count !== 7'(model_count)) begin n_err++; $display("[TB] FAIL later_timeout: got pulses=%0d count=%0d required 1/0", timeout_seen - base, o_byte_count); end
  endtask

  task automatic test_odd_abort();
    logic [FW-1:0] exp;
    int base_v;
    int base_t;
    int t;
    hard_reset();
    base_v = valid_rises;
    base_t = timeout_seen;
    for (int i = 0; i < NB - 1; i++) send_byte(8'(8'h80 + i), 1'b0, 1);
    send_ack();
    n_vec++;
    if (o_byte_count !== 7'(model_count) || o_frame_valid !== 1'b0) begin n_err++; $display("[TB] FAIL ack_ignored: got count=%0d valid=%b required %0d/0", o_byte_count, o_frame_valid, model_count); end
    idle(TMO + 4);
    @(negedge i_clk);
    n_vec++;
    if (valid_rises !== base_v || timeout_seen - base_t !== 1 || o_byte_count !== 7'(model_count)) begin
      n_err++;
      $display("[TB] FAIL odd_abort: got rises=%0d timeouts=%0d count=%0d required 0/1/0", valid_rises - base_v, timeout_seen - base_t, o_byte_count);
    end
    for (int i = 0; i < NB; i++) send_byte(8'(8'h10 + i), 1'b0, 2);
    t = 0;
    while (o_frame_valid !== 1'b1 && t < 4) begin @(negedge i_clk); t++; end
    n_vec++;
    if (o_frame_valid !== 1'b1 || exp_frames.size() == 0) begin n_err++; $display("[TB] FAIL sb_after_abort: got valid=%b queued=%0d required valid frame", o_frame_valid, exp_frames.size()); end
    else begin
      exp = exp_frames.pop_front();
      if (o_frame !== exp) begin n_err++; $display("[TB] FAIL sb_after_abort: got %h required %h", o_frame, exp); end
    end
    n_vec++;
    if (o_frame[31*16 +: 16] !== 16'h4F4E) begin n_err++; $display("[TB] FAIL sample31_fresh: got %h required 4f4e", o_frame[31*16 +: 16]); end
    send_ack();
    n_vec++;
    if (exp_frames.size() != 0) begin n_err++; $display("[TB] FAIL sb_leftover: got %0d frames required 0", exp_frames.size()); end
  endtask

  initial begin
    $display("[TB] starting uart_frame_assembler bench");
    test_reset();
    test_full_frame();
    test_backpressure();
    test_ack_with_byte();
    test_timeout();
    test_odd_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
